// File: rtl/adc_sample_capture.sv
// Serial ADC front end: paces samples, clocks a 16-SCLK ADC frame and emits signed Q-format u with a one-cycle EN strobe.
// Optional sticky overrun output when ADC_OVERRUN_FLAG_EN is defined.
module adc_sample_capture #(
  parameter int size       = 22,
  parameter int pf         = 14,
  parameter int ADC_BITS   = 12,
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 2000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            sdata,
  output logic            cs_n,
  output logic            sclk,
  output logic [size-1:0] u,
  output logic            EN,
  output logic            busy
`ifdef ADC_OVERRUN_FLAG_EN
  ,
  output logic            overrun
`endif
);

  localparam int TW        = $clog2(SAMPLE_DIV);
  localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SHIFT_AMT = pf - ADC_BITS + 1;
  localparam logic [TW-1:0] CNT_MAX = TW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       div_q, div_d;
  logic [4:0]          half_q, half_d;
  logic [ADC_BITS-1:0] sh_q, sh_d;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic                busy_q, busy_d;
  logic                en_q, en_d;
  logic [size-1:0]     u_q, u_d;
  logic                tick;
  logic                frame_active;
  logic [ADC_BITS-1:0] s_tc;
  logic [size-1:0]     s_ext;
  logic [size-1:0]     conv;

  // Offset binary to two's complement is just an MSB flip.
  assign s_tc  = {~sh_q[ADC_BITS-1], sh_q[ADC_BITS-2:0]};
  assign s_ext = {{(size-ADC_BITS){s_tc[ADC_BITS-1]}}, s_tc};
  assign conv  = s_ext << SHIFT_AMT;

  always_comb begin
    tick    = run && (cnt_q == CNT_MAX);
    cnt_d   = '0;
    if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = CS_SETUP;
          div_d   = '0;
        end
      end
      CS_SETUP: begin
        if (div_q == DIV_MAX) begin
          state_d = SHIFT;
          div_d   = '0;
          half_d  = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_MAX) begin
          div_d = '0;
          if (half_q == 5'd31) begin
            state_d = DONE;
          end else begin
            half_d = half_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    frame_active = (state_d == CS_SETUP) || (state_d == SHIFT);
    cs_n_d = ~frame_active;
    busy_d = frame_active;
    sclk_d = (state_d == SHIFT) ? half_d[0] : 1'b1;
    en_d   = (state_d == DONE);
    u_d    = en_d ? conv : u_q;
    // Register is only ADC_BITS wide, so the leading frame bits fall off the top.
    sh_d   = (state_d == SHIFT && sclk_d && !sclk_q) ? {sh_q[ADC_BITS-2:0], sdata} : sh_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      half_q  <= '0;
      sh_q    <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      u_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      half_q  <= half_d;
      sh_q    <= sh_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      u_q     <= u_d;
    end
  end

  assign cs_n = cs_n_q;
  assign sclk = sclk_q;
  assign busy = busy_q;
  assign EN   = en_q;
  assign u    = u_q;

`ifdef ADC_OVERRUN_FLAG_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q | (tick && (state_q != IDLE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_adc_sample_capture.sv
// Directed bench for adc_sample_capture: ADC serial model, timing, conversion, reset abort and overrun.
module tb_adc_sample_capture;

  logic        clk = 1'b0;
  logic        rst, run, sdata;
  logic        cs_n, sclk, en, busy;
  logic [21:0] u;
  logic        run2, sdata2;
  logic        cs_n2, sclk2, en2, busy2;
  logic [21:0] u2;
`ifdef ADC_OVERRUN_FLAG_EN
  logic        overrun1, overrun2;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] adc_word;
  logic [15:0] frame_word;
  int          bit_idx;

  always #5 clk = ~clk;

  adc_sample_capture dut (
    .clk(clk), .rst(rst), .run(run), .sdata(sdata),
    .cs_n(cs_n), .sclk(sclk), .u(u), .EN(en), .busy(busy)
`ifdef ADC_OVERRUN_FLAG_EN
    , .overrun(overrun1)
`endif
  );

  adc_sample_capture #(.SAMPLE_DIV(100)) dut2 (
    .clk(clk), .rst(rst), .run(run2), .sdata(sdata2),
    .cs_n(cs_n2), .sclk(sclk2), .u(u2), .EN(en2), .busy(busy2)
`ifdef ADC_OVERRUN_FLAG_EN
    , .overrun(overrun2)
`endif
  );

  // ADC model: latches the word when CS falls, presents one bit per SCLK falling edge, MSB first.
  initial begin
    sdata   = 1'b0;
    bit_idx = 15;
    forever begin
      @(negedge cs_n or negedge sclk);
      if (cs_n === 1'b0) begin
        if (sclk === 1'b1) begin
          frame_word = adc_word;
          bit_idx    = 15;
        end else begin
          sdata = frame_word[bit_idx];
          if (bit_idx > 0) bit_idx--;
        end
      end
    end
  end

  task automatic wait_en(input int bound, output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (en !== 1'b1 && edges < bound);
  endtask

  task automatic wait_en2(input int bound, output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (en2 !== 1'b1 && edges < bound);
  endtask

  task automatic wait_cs_fall(input int bound, output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (cs_n !== 1'b0 && edges < bound);
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; run2 = 1'b0; sdata2 = 1'b1; adc_word = 16'h0800;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (cs_n !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
    n_cmp++; if (sclk !== 1'b1) begin n_bad++; $display("FAIL reset_sclk: got %b want 1", sclk); end
    n_cmp++; if (u !== 22'h0) begin n_bad++; $display("FAIL reset_u: got %h want 000000", u); end
    n_cmp++; if (en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", en); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_first_frame();
    int n, k, cs_low, rises;
    logic prev;
    adc_word = 16'h0800;
    rst = 1'b0; run = 1'b1;
    wait_cs_fall(3000, n);
    n_cmp++; if (n != 2000) begin n_bad++; $display("FAIL first_cs_fall: got %0d cycles want 2000", n); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL setup_busy: got %b want 1", busy); end
    n_cmp++; if (sclk !== 1'b1) begin n_bad++; $display("FAIL setup_sclk: got %b want 1", sclk); end
    cs_low = 1; rises = 0; k = 0; prev = sclk;
    while (en !== 1'b1 && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (cs_n === 1'b0) cs_low++;
      if (sclk === 1'b1 && prev === 1'b0) rises++;
      prev = sclk;
    end
    n_cmp++; if (k != 132) begin n_bad++; $display("FAIL en_latency: got %0d cycles after cs fall want 132", k); end
    n_cmp++; if (cs_low != 132) begin n_bad++; $display("FAIL cs_low_len: got %0d want 132", cs_low); end
    n_cmp++; if (rises != 16) begin n_bad++; $display("FAIL sclk_rises: got %0d want 16", rises); end
    n_cmp++; if (u !== 22'h0) begin n_bad++; $display("FAIL code_800: got %h want 000000", u); end
    $display("frame code 800 -> u %h", u);
  endtask

  task automatic test_codes();
    logic [15:0] words [4];
    logic [21:0] exp_u [4];
    int e;
    words = '{16'h0801, 16'h0FFF, 16'h0000, 16'hF123};
    exp_u = '{22'h000008, 22'h003FF8, 22'h3FC000, 22'h3FC918};
    for (int i = 0; i < 4; i++) begin
      adc_word = words[i];
      wait_en(2100, e);
      n_cmp++; if (e != 2000) begin n_bad++; $display("FAIL en_period_%0d: got %0d want 2000", i, e); end
      n_cmp++; if (u !== exp_u[i]) begin n_bad++; $display("FAIL code_%h: got %h want %h", words[i], u, exp_u[i]); end
      $display("frame word %h -> u %h", words[i], u);
    end
    @(posedge clk); #1;
    n_cmp++; if (en !== 1'b0) begin n_bad++; $display("FAIL en_single_cycle: got %b want 0", en); end
    n_cmp++; if (u !== 22'h3FC918) begin n_bad++; $display("FAIL u_hold: got %h want 3fc918", u); end
  endtask

  task automatic test_run_stop();
    int e, n, lows, ens;
    adc_word = 16'h0FFF;
    wait_cs_fall(2100, n);
    run = 1'b0;
    wait_en(200, e);
    n_cmp++; if (e != 132) begin n_bad++; $display("FAIL runstop_en: got %0d cycles want 132", e); end
    n_cmp++; if (u !== 22'h003FF8) begin n_bad++; $display("FAIL runstop_u: got %h want 003ff8", u); end
    lows = 0; ens = 0;
    repeat (2500) begin
      @(posedge clk); #1;
      if (cs_n === 1'b0) lows++;
      if (en === 1'b1) ens++;
    end
    n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL idle_cs_low: got %0d want 0", lows); end
    n_cmp++; if (ens != 0) begin n_bad++; $display("FAIL idle_en: got %0d want 0", ens); end
  endtask

  task automatic test_reset_midframe();
    int n, k, rises, e;
    logic prev;
    adc_word = 16'h0800;
    run = 1'b1;
    wait_cs_fall(2100, n);
    rises = 0; k = 0; prev = sclk;
    while (rises < 8 && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (sclk === 1'b1 && prev === 1'b0) rises++;
      prev = sclk;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (cs_n !== 1'b1) begin n_bad++; $display("FAIL abort_cs_n: got %b want 1", cs_n); end
    n_cmp++; if (sclk !== 1'b1) begin n_bad++; $display("FAIL abort_sclk: got %b want 1", sclk); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (en !== 1'b0) begin n_bad++; $display("FAIL abort_en: got %b want 0", en); end
    n_cmp++; if (u !== 22'h0) begin n_bad++; $display("FAIL abort_u: got %h want 000000", u); end
    @(posedge clk); #1;
    rst = 1'b0;
    adc_word = 16'h0801;
    wait_en(2200, e);
    n_cmp++; if (e != 2132) begin n_bad++; $display("FAIL post_abort_en: got %0d cycles want 2132", e); end
    n_cmp++; if (u !== 22'h000008) begin n_bad++; $display("FAIL post_abort_u: got %h want 000008", u); end
    $display("frame after abort word 0801 -> u %h", u);
  endtask

  task automatic test_overrun();
    int e;
`ifdef ADC_OVERRUN_FLAG_EN
    n_cmp++; if (overrun2 !== 1'b0) begin n_bad++; $display("FAIL overrun_init: got %b want 0", overrun2); end
`endif
    run2 = 1'b1;
    wait_en2(400, e);
    n_cmp++; if (e != 232) begin n_bad++; $display("FAIL ovr_first_en: got %0d cycles want 232", e); end
    n_cmp++; if (u2 !== 22'h003FF8) begin n_bad++; $display("FAIL ovr_u: got %h want 003ff8", u2); end
    wait_en2(400, e);
    n_cmp++; if (e != 200) begin n_bad++; $display("FAIL ovr_period1: got %0d want 200", e); end
`ifdef ADC_OVERRUN_FLAG_EN
    n_cmp++; if (overrun2 !== 1'b1) begin n_bad++; $display("FAIL overrun_set: got %b want 1", overrun2); end
`endif
    wait_en2(400, e);
    n_cmp++; if (e != 200) begin n_bad++; $display("FAIL ovr_period2: got %0d want 200", e); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (u2 !== 22'h0) begin n_bad++; $display("FAIL ovr_rst_u: got %h want 000000", u2); end
`ifdef ADC_OVERRUN_FLAG_EN
    n_cmp++; if (overrun2 !== 1'b0) begin n_bad++; $display("FAIL overrun_clear: got %b want 0", overrun2); end
`endif
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_codes();
    test_run_stop();
    test_reset_midframe();
    test_overrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
